// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants: widths and ALU opcodes.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // A flushed slot carries a harmless add of zeros.
  localparam logic [3:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/operand_stage_if.sv
// Decode, write-back and ID/EX operand bundle between decode/hazard logic and the operand stage.
interface operand_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic                 valid_in;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [XLEN-1:0]      imm;
  logic                 alu_src;
  logic [3:0]           alu_control_in;
  logic [REG_IDX_W-1:0] rd_in;
  logic                 reg_write_in;
  logic                 stall;
  logic                 flush;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic [XLEN-1:0]      a;
  logic [XLEN-1:0]      b;
  logic [3:0]           ALUControl;
  logic [XLEN-1:0]      store_data;
  logic [REG_IDX_W-1:0] rd_out;
  logic                 reg_write_out;
  logic                 valid_out;

  modport master (
    output valid_in, rs1, rs2, imm, alu_src, alu_control_in, rd_in, reg_write_in,
    output stall, flush, wb_we, wb_rd, wb_data,
    input  a, b, ALUControl, store_data, rd_out, reg_write_out, valid_out
  );

  modport slave (
    input  valid_in, rs1, rs2, imm, alu_src, alu_control_in, rd_in, reg_write_in,
    input  stall, flush, wb_we, wb_rd, wb_data,
    output a, b, ALUControl, store_data, rd_out, reg_write_out, valid_out
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port,
// hard-wired x0 and write-first bypass from the write port.
module reg_file
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      mem_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) begin
      rs1_data = (wb_we && (wb_rd == rs1)) ? wb_data : mem_q[rs1];
    end
    if (rs2 != '0) begin
      rs2_data = (wb_we && (wb_rd == rs2)) ? wb_data : mem_q[rs2];
    end
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: register read with bypass, operand-B select and the
// stallable/flushable pipeline register feeding the ALU.
module operand_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  operand_stage_if.slave  bus
);

  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;

  logic [XLEN-1:0]      a_d, a_q;
  logic [XLEN-1:0]      b_d, b_q;
  logic [3:0]           ctrl_d, ctrl_q;
  logic [XLEN-1:0]      store_d, store_q;
  logic [REG_IDX_W-1:0] rd_d, rd_q;
  logic                 rw_d, rw_q;
  logic                 valid_d, valid_q;

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_we    (bus.wb_we),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data)
  );

  // Hold by default; flush overrides stall.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    store_d = store_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    if (bus.flush) begin
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = ALU_BUBBLE;
      store_d = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      a_d     = rs1_data;
      b_d     = bus.alu_src ? bus.imm : rs2_data;
      ctrl_d  = bus.alu_control_in;
      store_d = rs2_data;
      rd_d    = bus.rd_in;
      rw_d    = bus.reg_write_in;
      valid_d = bus.valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= ALU_AND;
      store_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a             = a_q;
  assign bus.b             = b_q;
  assign bus.ALUControl    = ctrl_q;
  assign bus.store_data    = store_q;
  assign bus.rd_out        = rd_q;
  assign bus.reg_write_out = rw_q;
  assign bus.valid_out     = valid_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed vector bench for operand_stage: table of per-cycle inputs and
// the expected registered outputs after that cycle's rising edge.
module tb_operand_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        reset;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  operand_stage_if #(.XLEN(32)) bus ();

  operand_stage #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t dec(logic v, logic [4:0] r1, logic [4:0] r2, logic [31:0] im,
                              logic src, logic [3:0] c, logic [4:0] d, logic w);
    in_t i;
    i = '0;
    i.valid = v; i.rs1 = r1; i.rs2 = r2; i.imm = im;
    i.alu_src = src; i.ctrl = c; i.rd = d; i.rw = w;
    return i;
  endfunction

  function automatic in_t wb(in_t i, logic [4:0] r, logic [31:0] dat);
    in_t o;
    o = i;
    o.wb_we = 1'b1; o.wb_rd = r; o.wb_data = dat;
    return o;
  endfunction

  function automatic in_t ctl(in_t i, logic rst, logic st, logic fl);
    in_t o;
    o = i;
    o.reset = rst; o.stall = st; o.flush = fl;
    return o;
  endfunction

  function automatic out_t ex(logic [31:0] a, logic [31:0] b, logic [3:0] c, logic [31:0] sd,
                              logic [4:0] d, logic w, logic v);
    out_t o;
    o.a = a; o.b = b; o.ctrl = c; o.sd = sd; o.rd = d; o.rw = w; o.valid = v;
    return o;
  endfunction

  task automatic add(in_t i, out_t e);
    vec_t v;
    v.in = i;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(in_t i);
    reset              = i.reset;
    bus.valid_in       = i.valid;
    bus.rs1            = i.rs1;
    bus.rs2            = i.rs2;
    bus.imm            = i.imm;
    bus.alu_src        = i.alu_src;
    bus.alu_control_in = i.ctrl;
    bus.rd_in          = i.rd;
    bus.reg_write_in   = i.rw;
    bus.stall          = i.stall;
    bus.flush          = i.flush;
    bus.wb_we          = i.wb_we;
    bus.wb_rd          = i.wb_rd;
    bus.wb_data        = i.wb_data;
  endtask

  // Apply one cycle of inputs, then compare just after the rising edge.
  task automatic step(string name, in_t i, out_t e);
    out_t act;
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1;
    act = ex(bus.a, bus.b, bus.ALUControl, bus.store_data, bus.rd_out,
             bus.reg_write_out, bus.valid_out);
    n_checks++;
    if (act !== e) begin
      n_errors++;
      $display("FAIL %s: got a=%h b=%h ctrl=%b sd=%h rd=%0d rw=%b v=%b, want a=%h b=%h ctrl=%b sd=%h rd=%0d rw=%b v=%b",
               name, act.a, act.b, act.ctrl, act.sd, act.rd, act.rw, act.valid,
               e.a, e.b, e.ctrl, e.sd, e.rd, e.rw, e.valid);
    end
  endtask

  initial begin
    drive(ctl('0, 1'b1, 1'b0, 1'b0));

    // Reset with a concurrent write-back: everything zero, ALUControl = AND.
    add(wb(ctl('0, 1'b1, 1'b0, 1'b0), 5'd5, 32'd99), ex(0, 0, ALU_AND, 0, 0, 0, 0));
    // x5 = 10; decode slot empty.
    add(wb('0, 5'd5, 32'd10), ex(0, 0, ALU_AND, 0, 0, 0, 0));
    // x6 = 5 bypassed on rs2, x5 from array.
    add(wb(dec(1, 5, 6, 0, 0, ALU_ADD, 8, 1), 5'd6, 32'd5), ex(10, 5, ALU_ADD, 5, 8, 1, 1));
    // Both from array.
    add(dec(1, 5, 6, 0, 0, ALU_ADD, 8, 1), ex(10, 5, ALU_ADD, 5, 8, 1, 1));
    // Bypass x7 = 0xFFFF on rs1.
    add(wb(dec(1, 7, 5, 0, 0, ALU_OR, 9, 1), 5'd7, 32'h0000FFFF),
        ex(32'h0000FFFF, 10, ALU_OR, 10, 9, 1, 1));
    // Write to x0 with x0 read: no bypass.
    add(wb(dec(1, 0, 0, 0, 0, ALU_AND, 0, 0), 5'd0, 32'hDEADBEEF), ex(0, 0, ALU_AND, 0, 0, 0, 1));
    // x0 still reads zero from the array.
    add(dec(1, 0, 0, 0, 0, ALU_ADD, 1, 1), ex(0, 0, ALU_ADD, 0, 1, 1, 1));
    // Immediate operand B; store_data keeps rs2.
    add(dec(1, 5, 6, 32'hFFFFFFF6, 1, ALU_ADD, 10, 1),
        ex(10, 32'hFFFFFFF6, ALU_ADD, 5, 10, 1, 1));
    // SUB of x7 = 7 with itself (bypass on both ports).
    add(wb(dec(1, 7, 7, 0, 0, ALU_SUB, 11, 1), 5'd7, 32'd7), ex(7, 7, ALU_SUB, 7, 11, 1, 1));
    // Three stall cycles with changing decode and write-backs.
    add(ctl(wb(dec(0, 5, 6, 0, 0, ALU_OR, 3, 0), 5'd7, 32'd1), 0, 1, 0),
        ex(7, 7, ALU_SUB, 7, 11, 1, 1));
    add(ctl(dec(1, 6, 5, 123, 1, ALU_AND, 4, 1), 0, 1, 0), ex(7, 7, ALU_SUB, 7, 11, 1, 1));
    add(ctl(wb(dec(1, 1, 2, 0, 0, ALU_ADD, 2, 0), 5'd9, 32'h55), 0, 1, 0),
        ex(7, 7, ALU_SUB, 7, 11, 1, 1));
    // Release: x7 now 1, x9 written during stall.
    add(dec(1, 7, 9, 0, 0, ALU_ADD, 12, 1), ex(1, 32'h55, ALU_ADD, 32'h55, 12, 1, 1));
    // Flush with stall: bubble.
    add(ctl(dec(1, 5, 6, 0, 0, ALU_SUB, 13, 1), 0, 1, 1), ex(0, 0, ALU_ADD, 0, 0, 0, 0));
    // Flush alone, write-back still commits.
    add(ctl(wb(dec(1, 5, 6, 0, 0, ALU_OR, 14, 1), 5'd8, 32'h1234), 0, 0, 1),
        ex(0, 0, ALU_ADD, 0, 0, 0, 0));
    add(dec(1, 8, 5, 0, 0, ALU_OR, 15, 1), ex(32'h1234, 10, ALU_OR, 10, 15, 1, 1));
    // Reset mid-stall with a write-back to x5: dropped.
    add(ctl(wb(dec(1, 5, 8, 0, 0, ALU_SUB, 16, 1), 5'd5, 32'h77), 1, 1, 0),
        ex(0, 0, ALU_AND, 0, 0, 0, 0));
    add(dec(1, 5, 8, 0, 0, ALU_ADD, 1, 1), ex(0, 0, ALU_ADD, 0, 1, 1, 1));

    foreach (vecs[k]) begin
      step($sformatf("vec%0d", k), vecs[k].in, vecs[k].exp);
    end

    // Long stall: five frozen cycles, then release picks up the write made mid-stall.
    step("long_load", wb(dec(1, 6, 6, 0, 0, ALU_SUB, 4, 1), 5'd6, 32'd3),
         ex(3, 3, ALU_SUB, 3, 4, 1, 1));
    step("long_stall0", ctl(wb(dec(0, 1, 2, 5, 1, ALU_AND, 0, 0), 5'd6, 32'd9), 0, 1, 0),
         ex(3, 3, ALU_SUB, 3, 4, 1, 1));
    for (int c = 1; c < 5; c++) begin
      step($sformatf("long_stall%0d", c), ctl(dec(0, 2, 1, 5, 1, ALU_OR, 0, 0), 0, 1, 0),
           ex(3, 3, ALU_SUB, 3, 4, 1, 1));
    end
    step("long_release", dec(1, 6, 6, 0, 0, ALU_SUB, 4, 1), ex(9, 9, ALU_SUB, 9, 4, 1, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Register file plus ID/EX operand register that feeds the ALU in the RV32I pipeline. It reads `rs1`/`rs2` and applies write-back bypass. It selects register or immediate for operand B, then registers `a`, `b` and `ALUControl` so the ALU sees stable operands one cycle after decode. It also supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREGS`, 32, architectural registers (index width 5)

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock
- `reset`  in  1  synchronous, active-high
- `valid_in`  in  1  decode slot holds a real instruction
- `rs1`, `rs2`  in  5  source register indices
- `imm`  in  XLEN  sign-extended immediate
- `alu_src`  in  1  1: B = `imm`; 0: B = rs2 data
- `alu_control_in`  in  4  ALU opcode from ALU control
- `rd_in`  in  5  destination index
- `reg_write_in`  in  1  instruction writes `rd`
- `stall`  in  1  hold the operand register
- `flush`  in  1  load a bubble
- `wb_we`  in  1  write-back enable
- `wb_rd`  in  5  write-back index
- `wb_data`  in  XLEN  write-back value
- `a`  out  XLEN  registered ALU operand A
- `b`  out  XLEN  registered ALU operand B
- `ALUControl`  out  4  registered ALU opcode
- `store_data`  out  XLEN  registered rs2 data, before the immediate mux
- `rd_out`  out  5  registered destination
- `reg_write_out`  out  1  registered write enable
- `valid_out`  out  1  registered valid

## Operation
- Register file:
  - `NREGS` x `XLEN`, two combinational read ports and one write port.
  - Written on the rising edge when `wb_we` = 1 and `wb_rd` != 0.
  - x0 always reads 0; writes to x0 are discarded.
- Bypass: if `wb_we` = 1, `wb_rd` == `rsN` and `rsN` != 0, read port N returns `wb_data` in the same cycle (write-first).
- Operand B = `alu_src` ? `imm` : rs2_data. `store_data` = rs2_data (bypassed).
- Operand register update priority per edge is reset > flush > stall > load:
  - reset: all outputs 0; all 32 registers cleared to 0.
  - flush: bubble. `a` = `b` = `store_data` = 0, `ALUControl` = ADD (0010), `rd_out` = 0, `reg_write_out` = 0, `valid_out` = 0.
  - stall: all outputs hold their previous values.
  - load: all outputs take the decode-side values.
- Register file write is independent of stall/flush: write-back commits even while stalled or flushing. Write-back is suppressed only by `reset`.
- A write-back issued in the same cycle as `reset` is dropped; the register stays 0.
- `flush` and `stall` asserted together: flush wins.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Latency is 1 cycle: decode inputs sampled at edge N appear on `a`/`b`/`ALUControl` after edge N.
- A write-back at edge N is visible to a decode read in the same cycle through the bypass, and from the array from cycle N+1 onward.
- Reset values: every output 0, including `ALUControl` = 0000 (AND).
  - Harmless, because `valid_out` = 0.
- Stall can last any number of cycles. Outputs are bit-stable for its whole duration.
- On release, the next edge loads whatever decode presents.
- Held operands are not re-read during a stall. The hazard unit must keep decode inputs stable or re-present them.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first load happens on the edge after `reset` deasserts.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU opcode constants: `ALU_AND` = 0000, `ALU_OR` = 0001, `ALU_ADD` = 0010, `ALU_SUB` = 0110.
  - `XLEN` and the register-index width.
  - Bubble opcode = `ALU_ADD`.
- Sub-module `reg_file` contains the array, the x0 rule and the bypass. The operand mux and pipeline register live in `operand_stage`.

## Test plan
- Reset, then write x5 = 10 and x6 = 5. Present rs1 = 5, rs2 = 6, `alu_src` = 0, ADD -> next cycle `a` = 10, `b` = 5, `ALUControl` = 0010, `valid_out` = 1.
- `wb_we` = 1, `wb_rd` = 7, `wb_data` = 0x0000FFFF in the same cycle as a read of rs1 = 7 -> `a` = 0x0000FFFF after the edge (bypass).
- Write x0 = 0xDEADBEEF, then read rs1 = 0, rs2 = 0 -> `a` = `b` = 0; bypass not applied.
- `alu_src` = 1, `imm` = 0xFFFFFFF6, rs2 = x6 (5) -> `b` = 0xFFFFFFF6, `store_data` = 5.
- Load SUB operands (7, 7), then stall 3 cycles while changing decode inputs. Meanwhile write-back x7 = 1 -> outputs frozen at 7/7/0110 for the 3 cycles, and x7 reads 1 afterwards.
- `flush` and `stall` together -> bubble: `a` = `b` = 0, `ALUControl` = 0010, `valid_out` = 0. Then `reset` with `wb_we` = 1 to x5 -> x5 reads 0 afterwards.
